// File: rtl/evt_pulse_gen.sv
// Burst pulse generator: emits N single-cycle evt_out pulses spaced by P clocks per request.
// Optional EVT_PULSE_GEN_SENT_COUNT_EN adds a wrapping count of pulses emitted since reset.
module evt_pulse_gen #(
    parameter  int MAX_COUNT = 115_200,
    parameter  int PERIOD_W  = 16,
    localparam int CW        = $clog2(MAX_COUNT)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                req_valid_in,
    output logic                req_ready_out,
    input  logic [CW-1:0]       count_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                abort_in,
    output logic                evt_out,
    output logic                busy_out,
    output logic [CW-1:0]       remaining_out,
    output logic                done_out
`ifdef EVT_PULSE_GEN_SENT_COUNT_EN
    ,
    output logic [CW-1:0]       sent_count_out
`endif
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       remaining;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W-1:0] per_reload;
    logic [CW-1:0]       count_eff;
    logic [PERIOD_W-1:0] period_m1;
    logic                handshake;
    logic                pulse;
    logic                last;

    assign count_eff = (count_in > CNT_MAX) ? CNT_MAX : count_in;
    // Period 0 behaves as 1, so the reload value saturates at 0.
    assign period_m1 = (period_in == '0) ? '0 : period_in - 1'b1;
    assign handshake = req_valid_in && (state == IDLE);
    // Abort is combinational so a pulse landing in the abort cycle is suppressed.
    assign pulse     = (state == RUN) && (per_cnt == '0) && !abort_in;
    assign last      = pulse && (remaining == CW'(1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready_out = 1'b0;
        busy_out      = 1'b0;
        done_out      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_out = 1'b1;
                if (handshake) state_nxt = (count_eff == '0) ? DONE : RUN;
            end
            RUN: begin
                busy_out = 1'b1;
                if (abort_in || last) state_nxt = DONE;
            end
            DONE: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            remaining  <= '0;
            per_cnt    <= '0;
            per_reload <= '0;
        end else begin
            case (state)
                IDLE: if (handshake) begin
                    remaining  <= count_eff;
                    per_cnt    <= '0;
                    per_reload <= period_m1;
                end
                RUN: begin
                    if (abort_in) begin
                        remaining <= '0;
                    end else if (pulse) begin
                        remaining <= remaining - 1'b1;
                        per_cnt   <= per_reload;
                    end else begin
                        per_cnt <= per_cnt - 1'b1;
                    end
                end
                default: begin
                    remaining <= '0;
                    per_cnt   <= '0;
                end
            endcase
        end
    end

    assign evt_out       = pulse;
    assign remaining_out = remaining;

`ifdef EVT_PULSE_GEN_SENT_COUNT_EN
    logic [CW-1:0] sent_count;

    // Wraps at MAX_COUNT so it tracks a downstream counter of the same modulus.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   sent_count <= '0;
        else if (pulse)  sent_count <= (sent_count == CNT_MAX) ? '0 : sent_count + 1'b1;
    end

    assign sent_count_out = sent_count;
`endif

endmodule
